// File: rtl/prog_loader.sv
// Framed byte-stream program loader: parses SYNC/addr/len/data/csum frames, writes RAM, gates CPU reset.
// Optional mid-frame idle abort is enabled by defining LOADER_TIMEOUT_EN.
module prog_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_WRITE, S_CSUM
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [7:0]  r_data, w_data_nxt;
    logic [8:0]  r_cnt, w_cnt_nxt;
    logic [7:0]  r_sum, w_sum_nxt;
    logic        r_we, w_we_nxt;
    logic        r_rdy, w_rdy_nxt;
    logic        r_hold, w_hold_nxt;
    logic        r_done, w_done_nxt;
    logic        r_err, w_err_nxt;
    logic        w_xfer;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to, w_to_nxt;
`endif

    assign w_xfer = in_valid & r_rdy;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_sum_nxt   = r_sum;
        w_hold_nxt  = r_hold;
        w_done_nxt  = r_done;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: if (w_xfer && in_data == SYNC_BYTE) begin
                w_state_nxt = S_ADDR_H;
                w_hold_nxt  = 1'b1;
                w_done_nxt  = 1'b0;
                w_err_nxt   = 1'b0;
            end
            S_ADDR_H: if (w_xfer) begin
                w_addr_nxt  = {in_data, r_addr[7:0]};
                w_state_nxt = S_ADDR_L;
            end
            S_ADDR_L: if (w_xfer) begin
                w_addr_nxt  = {r_addr[15:8], in_data};
                w_state_nxt = S_LEN;
            end
            S_LEN: if (w_xfer) begin
                w_cnt_nxt   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                w_sum_nxt   = 8'd0;
                w_state_nxt = S_DATA;
            end
            S_DATA: if (w_xfer) begin
                w_data_nxt  = in_data;
                w_sum_nxt   = r_sum + in_data;
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_addr_nxt  = r_addr + 16'd1;
                w_cnt_nxt   = r_cnt - 9'd1;
                w_state_nxt = (r_cnt == 9'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: if (w_xfer) begin
                if (in_data == r_sum) begin
                    w_done_nxt = 1'b1;
                    w_hold_nxt = 1'b0;
                end else begin
                    w_err_nxt  = 1'b1;
                end
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
`ifdef LOADER_TIMEOUT_EN
        // Count consecutive stalled cycles inside a frame; abort when the budget runs out
        w_to_nxt = '0;
        if (r_state != S_IDLE && !w_xfer) begin
            if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
                w_state_nxt = S_IDLE;
                w_err_nxt   = 1'b1;
                w_done_nxt  = 1'b0;
                w_hold_nxt  = 1'b1;
            end else begin
                w_to_nxt = r_to + TW'(1);
            end
        end
`endif
        w_we_nxt  = (w_state_nxt == S_WRITE);
        w_rdy_nxt = (w_state_nxt != S_WRITE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr  <= 16'd0;
            r_data  <= 8'd0;
            r_cnt   <= 9'd0;
            r_sum   <= 8'd0;
            r_we    <= 1'b0;
            r_rdy   <= 1'b1;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            r_to    <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sum   <= w_sum_nxt;
            r_we    <= w_we_nxt;
            r_rdy   <= w_rdy_nxt;
            r_hold  <= w_hold_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
`ifdef LOADER_TIMEOUT_EN
            r_to    <= w_to_nxt;
`endif
        end
    end

    assign in_ready = r_rdy;
    assign mem_we   = r_we;
    assign mem_addr = r_addr;
    assign mem_data = r_data;
    assign cpu_hold = r_hold;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: frame-level reference model queues expected RAM writes.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, cpu_hold, done, err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] fdata[$];
    int         checks = 0;
    int         errors = 0;

    prog_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected-write queue
    initial begin
        logic prev_we;
        wr_t  e;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                chk("ready_vs_we", 32'(in_ready), 32'(!mem_we));
                if (mem_we === 1'b1) begin
                    chk("we_pulse_width", 32'(prev_we), 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write addr=%0h data=%0h", mem_addr, mem_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(mem_addr), 32'(e.a));
                        chk("wr_data", 32'(mem_data), 32'(e.d));
                    end
                end
                prev_we = mem_we;
            end else begin
                prev_we = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    // Present a byte until accepted; optional random idle gap before it
    task automatic send_byte(input logic [7:0] b, input int max_stall);
        int n;
        n = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
        idle(n);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            if (in_ready === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout byte=%0h actual=not_accepted required=accepted", b);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_mem_we"},   32'(mem_we),   32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_data"}, 32'(mem_data), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_err"},      32'(err),      32'd0);
    endtask

    // Reference model at frame level: writes go to a+i (mod 2^16), good iff csum == sum of data
    task automatic send_frame(input string tag, input logic [15:0] a, input logic [7:0] xr, input int stall);
        logic [7:0] sum;
        logic [7:0] cs;
        wr_t        w;
        sum = 8'd0;
        for (int i = 0; i < fdata.size(); i++) begin
            w.a = a + 16'(i);
            w.d = fdata[i];
            exp_q.push_back(w);
            sum = sum + fdata[i];
        end
        cs = sum ^ xr;
        send_byte(8'hA5, stall);
        send_byte(a[15:8], stall);
        send_byte(a[7:0], stall);
        send_byte(8'(fdata.size()), stall);
        for (int i = 0; i < fdata.size(); i++) send_byte(fdata[i], stall);
        send_byte(cs, stall);
        idle(2);
        chk({tag, "_done"},     32'(done),     (xr == 8'd0) ? 32'd1 : 32'd0);
        chk({tag, "_err"},      32'(err),      (xr == 8'd0) ? 32'd0 : 32'd1);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), (xr == 8'd0) ? 32'd0 : 32'd1);
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] ra;
        int          rl;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;
        idle(2);

        fdata = '{8'h11, 8'h22, 8'h33};
        send_frame("good", 16'h0100, 8'h00, 0);

        fdata = '{8'h7F};
        send_frame("badcsum", 16'h0010, 8'h7F, 0);

        fdata.delete();
        for (int i = 0; i < 256; i++) fdata.push_back(8'h01);
        send_frame("wrap256", 16'hFFFF, 8'h00, 0);

        for (int k = 0; k < 4; k++) begin
            fdata.delete();
            for (int i = 0; i < 4; i++) fdata.push_back(8'($urandom));
            send_frame("stall4", 16'($urandom), 8'h00, 3);
        end

        fdata = '{8'hA5, 8'hA5, 8'h00};
        send_frame("sync_in_data", 16'h00A5, 8'h00, 1);

        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset("midreset");
        @(negedge clk);
        rst = 1'b1;
        fdata = '{8'hDE, 8'hAD};
        send_frame("after_reset", 16'h2000, 8'h00, 0);

        for (int k = 0; k < 10; k++) begin
            fdata.delete();
            rl = int'($urandom_range(1, 20));
            for (int i = 0; i < rl; i++) fdata.push_back(8'($urandom));
            ra = 16'($urandom);
            send_frame("random", ra, ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 2);
        end

`ifdef LOADER_TIMEOUT_EN
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        idle(18);
        chk("timeout_err",  32'(err),      32'd1);
        chk("timeout_done", 32'(done),     32'd0);
        chk("timeout_hold", 32'(cpu_hold), 32'd1);
        fdata = '{8'h42};
        send_frame("post_timeout", 16'h0300, 8'h00, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream feeder for the SAP-2 core's memory: receives framed program bytes over a byte-wide valid/ready stream and writes them into RAM through a dedicated write port.
- Holds the CPU in reset (cpu_hold) while a frame loads; releases it once a frame completes with a good checksum.
- Sits between the chip input pins and the memory block; once released, the CPU runs from the loaded image.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1024, idle cycles mid-frame before abort; used only with LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts byte this cycle; transfer when in_valid & in_ready.
- mem_we  out  1  one-cycle RAM write strobe.
- mem_addr  out  16  write address.
- mem_data  out  8  write data.
- cpu_hold  out  1  high holds CPU in reset.
- done  out  1  sticky: last frame loaded, checksum good.
- err  out  1  sticky: last frame failed (checksum or timeout).

Behaviour:
- Reset (rst=0, async): state IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=1, done=0, err=0, counters 0.
- Frame format: SYNC_BYTE, addr_hi, addr_lo, len, len data bytes, csum. len=0 means 256 bytes. csum = 8-bit modular sum of the data bytes only.
- States: IDLE, ADDR_H, ADDR_L, LEN, DATA, WRITE, CSUM.
- IDLE: non-sync bytes are accepted and discarded. On SYNC_BYTE:
  - go to ADDR_H;
  - cpu_hold<=1, done<=0, err<=0.
- ADDR_H and ADDR_L: latch address bytes; then go to LEN.
- LEN: latch count (9-bit, 0 maps to 256); clear running sum; go to DATA.
- DATA: on transfer, register the byte into mem_data, add it to the sum, go to WRITE.
- WRITE (exactly 1 cycle, in_ready=0):
  - mem_we=1 with the current mem_addr and mem_data;
  - next cycle mem_addr increments by 1, wrapping 16'hFFFF to 16'h0000;
  - count decrements; count reaching 0 goes to CSUM, else back to DATA.
- Throughput: at most one data byte per 2 cycles. Latency from accepted data byte to mem_we is 1 cycle.
- CSUM: on transfer, compare with the sum, then return to IDLE.
  - Match: done<=1, cpu_hold<=0.
  - Mismatch: err<=1, cpu_hold stays 1.
- in_ready is 1 in every state except WRITE.
- mem_we never asserts outside WRITE.
- Stalls: in_valid low in any state holds the state indefinitely (subject to the optional timeout).
- SYNC_BYTE inside a frame (address, len, data or csum position) is treated as ordinary data, with no resync.
- Reset mid-frame: immediate return to reset values. The partially written RAM contents are left as they are.
- done and err are never both 1.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - a counter of consecutive cycles with the state not IDLE and no transfer;
  - when the count reaches TIMEOUT_CYCLES: err<=1, state<=IDLE, cpu_hold stays 1;
  - the counter clears on any transfer or in IDLE.
- Not defined: no counter; the loader waits forever mid-frame.

Test Plan:
- Good frame: A5 01 00 03 11 22 33 66 -> writes 0x11@0x0100, 0x22@0x0101, 0x33@0x0102 (three 1-cycle mem_we pulses), done=1, cpu_hold=0, err=0.
- Bad checksum: A5 00 10 01 7F 00 -> one write 0x7F@0x0010, err=1, done=0, cpu_hold=1.
- Wrap and len=0: A5 FF FF 00 followed by 256 bytes 0x01 and csum 00 -> addresses FFFF, 0000..00FE written, done=1.
- Backpressure and stalls: toggle in_valid randomly during a 4-byte frame -> in_ready=0 exactly on write cycles, no byte lost or duplicated, correct addresses.
- Garbage then reset: 00 FF A5 02 then rst=0 for 1 cycle -> outputs at reset values; a following good frame loads correctly.
- LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=16: A5 01 then in_valid=0 for 16 cycles -> err=1, state IDLE, next frame accepted.
